// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Multiply/divide execution unit for the pipelined MIPS core. It lives beside
// the ALU in EX, owns the HI/LO architectural registers and models a
// multi-cycle latency window for MULT/MULTU/DIV/DIVU. MTHI/MTLO write HI/LO
// in a single cycle. The read port (md_out) feeds MFHI/MFLO down the pipe.
//
// The arithmetic result is computed at the issuing edge and held in a
// pending register. HI/LO only take the new value at the completing edge,
// so md_out keeps showing the old HI/LO for the whole busy window.
//
// Parameters:
//   MULT_LAT  busy cycles for MULT/MULTU (>= 1)
//   DIV_LAT   busy cycles for DIV/DIVU   (>= 1)
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     request valid this cycle
//   md_op     0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   a, b      rs / rt operands
//   hilo_sel  read select: 1 = HI, 0 = LO
//   busy      multi-cycle operation in flight
//   md_out    hilo_sel ? HI : LO (combinational from registers)
//
// Configuration macro:
//   MD_DIVZERO_KEEP_EN  when defined, DIV/DIVU by zero leaves HI/LO unchanged
//                       at completion; when undefined, a divide by zero
//                       produces HI = a, LO = 0xFFFFFFFF.
// ---------------------------------------------------------------------------
module mult_div_unit #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hilo_sel,
   output logic        busy,
   output logic [31:0] md_out
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

`ifdef MD_DIVZERO_KEEP_EN
   localparam bit KEEP_ON_DIVZERO = 1'b1;
`else
   localparam bit KEEP_ON_DIVZERO = 1'b0;
`endif

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [63:0]        pending_q;
   logic               skip_q;
   logic [31:0]        hi_q;
   logic [31:0]        lo_q;

   logic               issue_md;
   logic               issue_mthi;
   logic               issue_mtlo;
   logic               done;

   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        abs_a;
   logic [31:0]        abs_b;
   logic [31:0]        div_s_den;
   logic [31:0]        q_mag;
   logic [31:0]        r_mag;
   logic [31:0]        q_s;
   logic [31:0]        r_s;
   logic [31:0]        div_u_den;
   logic [31:0]        q_u;
   logic [31:0]        r_u;
   logic               b_zero;
   logic               is_div;
   logic [63:0]        result;

   // Arithmetic for the request on the inputs, evaluated every cycle and
   // captured only on an accepted issue. Signed division works on magnitudes
   // so 0x80000000 / -1 wraps to 0x80000000 with a zero remainder instead of
   // overflowing. A zero divisor is replaced by 1 to keep the dividers
   // well defined; the real divide-by-zero result is selected separately.
   always_comb begin
      prod_s    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      prod_u    = {32'b0, a} * {32'b0, b};
      b_zero    = (b == 32'd0);
      is_div    = (md_op == 3'd2) || (md_op == 3'd3);
      abs_a     = a[31] ? (-a) : a;
      abs_b     = b[31] ? (-b) : b;
      div_s_den = b_zero ? 32'd1 : abs_b;
      q_mag     = abs_a / div_s_den;
      r_mag     = abs_a % div_s_den;
      q_s       = (a[31] ^ b[31]) ? (-q_mag) : q_mag;
      r_s       = a[31] ? (-r_mag) : r_mag;
      div_u_den = b_zero ? 32'd1 : b;
      q_u       = a / div_u_den;
      r_u       = a % div_u_den;
      result    = 64'd0;
      case (md_op)
         3'd0:    result = prod_s;
         3'd1:    result = prod_u;
         3'd2:    result = b_zero ? {a, 32'hFFFF_FFFF} : {r_s, q_s};
         3'd3:    result = b_zero ? {a, 32'hFFFF_FFFF} : {r_u, q_u};
         default: result = 64'd0;
      endcase
   end

   // State register for the IDLE/RUN sequencer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and issue decode. Requests are only honoured in IDLE; while
   // RUN every start, including MTHI/MTLO, is dropped. The completing edge is
   // the one on which the counter steps from 1 to 0.
   always_comb begin
      state_d    = state_q;
      issue_md   = 1'b0;
      issue_mthi = 1'b0;
      issue_mtlo = 1'b0;
      done       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (md_op[2] == 1'b0) begin
                  issue_md = 1'b1;
                  state_d  = RUN;
               end else if (md_op == 3'd4) begin
                  issue_mthi = 1'b1;
               end else if (md_op == 3'd5) begin
                  issue_mtlo = 1'b1;
               end
            end
         end
         RUN: begin
            if (cnt_q == CNT_W'(1)) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers: latency counter, pending result, divide-by-zero
   // keep flag and the architectural HI/LO. Reset also throws away any
   // pending result of an in-flight operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         pending_q <= 64'd0;
         skip_q    <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         if (issue_md) begin
            pending_q <= result;
            skip_q    <= KEEP_ON_DIVZERO && is_div && b_zero;
            cnt_q     <= md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
         end else if (state_q == RUN) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (issue_mthi) begin
            hi_q <= a;
         end
         if (issue_mtlo) begin
            lo_q <= a;
         end
         if (done && !skip_q) begin
            hi_q <= pending_q[63:32];
            lo_q <= pending_q[31:0];
         end
      end
   end

   // Output decode: busy is simply "in RUN"; the read port is a plain mux.
   always_comb begin
      busy   = (state_q == RUN);
      md_out = hilo_sel ? hi_q : lo_q;
   end

endmodule
